// File: rtl/btn_pkg.sv
// Shared defaults, counter sizing and the per-channel output bundle for the
// button reader.
package btn_pkg;

  localparam int NUM_BTN_DEF         = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  // Ceiling log2 with a floor of 1 bit, so a count of DEBOUNCE_CYCLES-1 always fits.
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < cycles) w = i + 1;
    return w;
  endfunction

  typedef struct packed {
    logic state;
    logic press;
    logic rel;
    logic led;
  } ch_out_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, saturating debounce counter,
// debounced level, edge pulses and press-toggled LED, all registered.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    btn,
  output ch_out_t out
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          state, press, rel, led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      led   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      // Any return to the accepted level discards the partial count.
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        state <= sync2;
        press <= sync2;
        rel   <= ~sync2;
        if (sync2) led <= ~led;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out = '{state: state, press: press, rel: rel, led: led};

endmodule

// File: rtl/btn_reader.sv
// Array of independent debounced push-button channels with press/release
// pulses and a per-channel toggle LED.
module btn_reader
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] led
);

  ch_out_t [NUM_BTN-1:0] ch_out;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .btn (btn[g]),
      .out (ch_out[g])
    );

    assign btn_state[g]   = ch_out[g].state;
    assign btn_press[g]   = ch_out[g].press;
    assign btn_release[g] = ch_out[g].rel;
    assign led[g]         = ch_out[g].led;
  end

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 Parameter NUM_BTN, default 4, number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive clean cycles required to accept a level change; legal range is at least 2.
REQ-003 Port clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port btn  input  NUM_BTN  raw, asynchronous, bouncing button levels, where 1 means pressed.
REQ-006 Port btn_state  output  NUM_BTN  debounced level per channel.
REQ-007 Port btn_press  output  NUM_BTN  one-cycle pulse on an accepted 0->1 change.
REQ-008 Port btn_release  output  NUM_BTN  one-cycle pulse on an accepted 1->0 change.
REQ-009 Port led  output  NUM_BTN  per-channel toggle register, inverted on each accepted press.

Function
REQ-010 Each btn bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-011 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE_CYCLES), which SHALL NOT wrap.
REQ-012 Counter rule: when sync2 equals btn_state, the counter SHALL clear to 0; when it differs and count is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync2 differs and count equals DEBOUNCE_CYCLES-1, the channel SHALL load btn_state from sync2 and clear the counter in the same edge.
REQ-014 btn_press (or btn_release) SHALL be high for exactly the one cycle after the edge where btn_state updates to 1 (or 0), and low otherwise.
REQ-015 Latency: if pin level is first sampled by sync1 at edge 0 and is held, btn_state and the pulse SHALL update at edge DEBOUNCE_CYCLES+1.
REQ-016 Any return of sync2 to btn_state before acceptance SHALL clear the counter; no state change and no pulse SHALL occur.
REQ-017 btn_press and btn_release SHALL never be high on the same channel in the same cycle.
REQ-018 A held level SHALL produce exactly one pulse; there is no auto-repeat.
REQ-019 led[i] SHALL toggle on the edge where btn_press[i] is asserted, so the new led value and the pulse appear in the same cycle.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on their own timing.
REQ-021 All outputs SHALL be registered, with no combinational path from btn to any output.

Reset
REQ-022 While rst is high, the following SHALL be 0 asynchronously: sync1, sync2, counters, btn_state, btn_press, btn_release and led.
REQ-023 A reset asserted mid-count SHALL discard the partial count; after release, acceptance SHALL restart from count 0.
REQ-024 If btn is held at 1 through reset, a press SHALL be accepted DEBOUNCE_CYCLES+1 edges after the first sampling edge following release, and one btn_press SHALL be issued.

Structure
REQ-025 Package btn_pkg SHALL hold the NUM_BTN default, the DEBOUNCE_CYCLES default and the counter-width constant function.
REQ-026 One sub-module, btn_debounce_ch, SHALL implement a single channel (synchronizer, counter, state, pulses, led toggle).
REQ-027 btn_reader SHALL instantiate NUM_BTN copies of btn_debounce_ch via a generate loop and concatenate their outputs.

Verification (DEBOUNCE_CYCLES=16, NUM_BTN=4)
REQ-028 Clean press: drive btn[0] 0->1 and hold -> btn_state[0]=1 and btn_press[0]=1 for one cycle at edge 17 after first sample; led[0]=1; other channels stay 0.
REQ-029 Glitch rejection: pulse btn[1] high for 10 cycles, then low -> no change on btn_state[1], btn_press[1] or led[1].
REQ-030 Bounce: toggle btn[2] every 3 cycles for 40 cycles, then hold 1 -> exactly one btn_press[2], 17 edges after the last toggle is sampled.
REQ-031 Release and double press on btn[3]: press, release, press, each phase held 30 cycles -> pulse sequence press, release, press; led[3] goes 1, then 0.
REQ-032 Reset mid-count: hold btn[0]=1 for 10 cycles, assert rst for 2 cycles, keep btn high -> all outputs 0 during reset; one btn_press[0] at 17 edges after the first post-reset sample.
REQ-033 Simultaneous change: raise all four btn bits on the same cycle -> all four btn_press bits pulse on the same cycle and no btn_release pulse occurs.
